mem_arbiter: RTL



---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arbiter_rr_pick2.sv | 20 ++
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for mem_arbiter: FSM states, memory_unit func codes and
// the reserved invalid func value.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_RDY = 2'd2,
      DONE     = 2'd3
   } arb_state_e;

   // Func codes mirror the memory_unit command set.
   localparam logic [1:0] GET_CONTENTS = 2'b00;
   localparam logic [1:0] SET_CONTENTS = 2'b01;
   localparam logic [1:0] GET_FREE     = 2'b10;
   localparam logic [1:0] INVALID_FUNC = 2'b11;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin select: a lone requester wins, and on
// contention the client that was not granted last wins.
module rr_pick2 (
   input  logic req0_i,
   input  logic req1_i,
   input  logic last_grant_i,
   output logic valid_o,
   output logic grant_o
);

   always_comb begin
      valid_o = req0_i | req1_i;
      if (req0_i && req1_i) begin
         grant_o = ~last_grant_i;
      end else begin
         grant_o = req1_i;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-client round-robin front end for the memory_unit command port.
// Optional grant counters are built when MEM_ARB_STATS_EN is defined.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 28
) (
   input  logic              clk,
   input  logic              rst,
`ifdef MEM_ARB_STATS_EN
   output logic [15:0]       c0_grants,
   output logic [15:0]       c1_grants,
`endif
   input  logic              c0_req,
   input  logic [1:0]        c0_func,
   input  logic [ADDR_W-1:0] c0_addr,
   input  logic [DATA_W-1:0] c0_wdata,
   output logic              c0_ack,
   input  logic              c1_req,
   input  logic [1:0]        c1_func,
   input  logic [ADDR_W-1:0] c1_addr,
   input  logic [DATA_W-1:0] c1_wdata,
   output logic              c1_ack,
   output logic [DATA_W-1:0] rsp_data,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic              rsp_err,
   output logic [1:0]        mem_func,
   output logic              mem_execute,
   output logic [ADDR_W-1:0] mem_addr_in,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [ADDR_W-1:0] mem_addr_out,
   input  logic [DATA_W-1:0] mem_data_out,
   input  logic              mem_is_ready
);

   arb_state_e        state_q;
   logic              last_grant_q;
   logic              gnt_q;
   logic              c0_ack_q, c1_ack_q, rsp_err_q, mem_execute_q;
   logic [1:0]        mem_func_q;
   logic [ADDR_W-1:0] mem_addr_q, rsp_addr_q;
   logic [DATA_W-1:0] mem_data_q, rsp_data_q;

   logic              pick_valid, pick_gnt;
   logic [1:0]        sel_func;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   rr_pick2 u_pick (
      .req0_i       (c0_req),
      .req1_i       (c1_req),
      .last_grant_i (last_grant_q),
      .valid_o      (pick_valid),
      .grant_o      (pick_gnt)
   );

   assign sel_func  = pick_gnt ? c1_func  : c0_func;
   assign sel_addr  = pick_gnt ? c1_addr  : c0_addr;
   assign sel_wdata = pick_gnt ? c1_wdata : c0_wdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         last_grant_q  <= 1'b1;
         gnt_q         <= 1'b0;
         c0_ack_q      <= 1'b0;
         c1_ack_q      <= 1'b0;
         rsp_err_q     <= 1'b0;
         mem_execute_q <= 1'b0;
         mem_func_q    <= '0;
         mem_addr_q    <= '0;
         mem_data_q    <= '0;
         rsp_addr_q    <= '0;
         rsp_data_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               // Requests are held off while memory_unit is still initialising.
               if (pick_valid && mem_is_ready) begin
                  gnt_q        <= pick_gnt;
                  last_grant_q <= pick_gnt;
                  mem_func_q   <= sel_func;
                  mem_addr_q   <= sel_addr;
                  mem_data_q   <= sel_wdata;
                  if (sel_func == INVALID_FUNC) begin
                     rsp_err_q <= 1'b1;
                     c0_ack_q  <= ~pick_gnt;
                     c1_ack_q  <= pick_gnt;
                     state_q   <= DONE;
                  end else begin
                     mem_execute_q <= 1'b1;
                     state_q       <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               mem_execute_q <= 1'b0;
               state_q       <= WAIT_RDY;
            end
            WAIT_RDY: begin
               if (mem_is_ready) begin
                  rsp_data_q <= mem_data_out;
                  rsp_addr_q <= mem_addr_out;
                  rsp_err_q  <= 1'b0;
                  c0_ack_q   <= ~gnt_q;
                  c1_ack_q   <= gnt_q;
                  state_q    <= DONE;
               end
            end
            DONE: begin
               c0_ack_q  <= 1'b0;
               c1_ack_q  <= 1'b0;
               rsp_err_q <= 1'b0;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign c0_ack      = c0_ack_q;
   assign c1_ack      = c1_ack_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_addr    = rsp_addr_q;
   assign mem_func    = mem_func_q;
   assign mem_execute = mem_execute_q;
   assign mem_addr_in = mem_addr_q;
   assign mem_data_in = mem_data_q;

`ifdef MEM_ARB_STATS_EN
   logic        grant_fire;
   logic [15:0] c0_grants_q, c0_grants_d;
   logic [15:0] c1_grants_q, c1_grants_d;

   // Invalid-func selections count as grants too.
   assign grant_fire = (state_q == IDLE) && pick_valid && mem_is_ready;

   always_comb begin
      c0_grants_d = c0_grants_q;
      c1_grants_d = c1_grants_q;
      if (grant_fire) begin
         if (pick_gnt) begin
            c1_grants_d = sat_inc16(c1_grants_q);
         end else begin
            c0_grants_d = sat_inc16(c0_grants_q);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         c0_grants_q <= '0;
         c1_grants_q <= '0;
      end else begin
         c0_grants_q <= c0_grants_d;
         c1_grants_q <= c1_grants_d;
      end
   end

   assign c0_grants = c0_grants_q;
   assign c1_grants = c1_grants_q;
`endif

endmodule
